// File: rtl/fetch_align.sv
// Halfword realignment buffer between fetch and decode: turns a stream of aligned
// 32-bit fetch words into whole RVC / 32-bit instructions with their PCs.
module fetch_align #(
  parameter int          BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_valid,
  input  logic [31:0] flush_addr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_rvc
);

  localparam int PTR_W = $clog2(BUF_HW);
  localparam int CNT_W = $clog2(BUF_HW + 1);
  localparam logic [CNT_W-1:0] RDY_LIM = CNT_W'(BUF_HW - 2);

  logic [15:0]      hw_q [BUF_HW];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             drop_q, drop_d;

  logic [15:0]      h0_s, h1_s;
  logic             h0_is32_s;
  logic             dec_valid_s, dec_rvc_s;
  logic [31:0]      dec_instr_s;
  logic             push_s, pop_s;
  logic [CNT_W-1:0] push_n_s, pop_n_s;
  logic             unused_addr_bit;

  assign unused_addr_bit = flush_addr[0];

  assign h0_s      = hw_q[rd_q];
  assign h1_s      = hw_q[rd_q + PTR_W'(1)];
  assign h0_is32_s = (h0_s[1:0] == 2'b11);

  // Instruction decode at the head of the buffer; a 32-bit head waits for its upper half.
  always_comb begin
    dec_valid_s = 1'b0;
    dec_rvc_s   = 1'b0;
    dec_instr_s = 32'h0;
    if ((cnt_q >= CNT_W'(1)) && !h0_is32_s) begin
      dec_valid_s = 1'b1;
      dec_rvc_s   = 1'b1;
      dec_instr_s = {16'h0, h0_s};
    end else if ((cnt_q >= CNT_W'(2)) && h0_is32_s) begin
      dec_valid_s = 1'b1;
      dec_rvc_s   = 1'b0;
      dec_instr_s = {h1_s, h0_s};
    end else begin
      dec_valid_s = 1'b0;
    end
  end

  // Ready looks only at the current fill level, so a push never relies on a same-cycle pop.
  assign fetch_ready = !flush_valid && (cnt_q <= RDY_LIM);
  assign out_valid   = dec_valid_s && !flush_valid;
  assign out_instr   = dec_instr_s;
  assign out_rvc     = dec_rvc_s;
  assign out_pc      = pc_q;

  assign push_s = fetch_valid && fetch_ready;
  assign pop_s  = out_valid && out_ready;

  // Next-state for pointers, fill level, PC and the post-redirect low-half drop.
  always_comb begin
    push_n_s = {CNT_W{1'b0}};
    pop_n_s  = {CNT_W{1'b0}};
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    if (flush_valid) begin
      rd_d   = {PTR_W{1'b0}};
      wr_d   = {PTR_W{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
      pc_d   = {flush_addr[31:1], 1'b0};
      drop_d = flush_addr[1];
    end else begin
      if (push_s) begin
        push_n_s = drop_q ? CNT_W'(1) : CNT_W'(2);
        wr_d     = wr_q + (drop_q ? PTR_W'(1) : PTR_W'(2));
        drop_d   = 1'b0;
      end else begin
        push_n_s = {CNT_W{1'b0}};
      end
      if (pop_s) begin
        pop_n_s = dec_rvc_s ? CNT_W'(1) : CNT_W'(2);
        rd_d    = rd_q + (dec_rvc_s ? PTR_W'(1) : PTR_W'(2));
        pc_d    = pc_q + (dec_rvc_s ? 32'd2 : 32'd4);
      end else begin
        pop_n_s = {CNT_W{1'b0}};
      end
      cnt_d = cnt_q + push_n_s - pop_n_s;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q   <= {PTR_W{1'b0}};
      wr_q   <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      pc_q   <= RESET_PC;
      drop_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Halfword storage; contents are only meaningful below the fill level, so no reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      if (drop_q) begin
        hw_q[wr_q] <= fetch_data[31:16];
      end else begin
        hw_q[wr_q]              <= fetch_data[15:0];
        hw_q[wr_q + PTR_W'(1)] <= fetch_data[31:16];
      end
    end
  end

endmodule
